reset_sequencer: RTL

Parametrised successor of the DAQ reset manager: generates per-domain active-low resets for the acquisition and DAC chains from the PS peripheral reset, an external trigger, a watchdog heartbeat and an instant-reset pin. Adds runtime-programmable timeouts, a sticky fault state with software clear, N maskable DAC domains, and a cycle-counted ramwriter release delay. Sits between the PS reset/config registers and all fabric datapath blocks; IO buffers stay outside.

---
 rtl/reset_sequencer_pkg.sv | 34 +++
 rtl/reset_sequencer_sync_edge.sv | 32 +++
 rtl/reset_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: gate FSM states,
// reset_cfg bit positions and reset_sts field positions.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } gate_state_e;

  // reset_cfg bit indices
  localparam int unsigned CFG_TRIG_MODE   = 0;
  localparam int unsigned CFG_WD_EN       = 1;
  localparam int unsigned CFG_MASTER_TRIG = 2;
  localparam int unsigned CFG_INST_EN     = 3;
  localparam int unsigned CFG_STICKY      = 4;
  localparam int unsigned CFG_FAULT_CLR   = 5;

  // reset_sts field positions
  localparam int unsigned STS_PERIPH   = 0;
  localparam int unsigned STS_ANY_DOM  = 1;
  localparam int unsigned STS_RAM      = 2;
  localparam int unsigned STS_XADC     = 3;
  localparam int unsigned STS_TRIG     = 4;
  localparam int unsigned STS_WD       = 5;
  localparam int unsigned STS_INST     = 6;
  localparam int unsigned STS_MTRIG    = 7;
  localparam int unsigned STS_STATE    = 8;
  localparam int unsigned STS_FAULT    = 10;
  localparam int unsigned STS_WD_FAULT = 11;
  localparam int unsigned STS_DOMAIN   = 12;

endpackage

// File: rtl/reset_sequencer_sync_edge.sv
// Multi-stage input synchroniser with single-cycle rise/fall pulses.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q;

  assign sync_d = {sync_q[STAGES-2:0], d_i};
  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

  // Shift chain plus one-cycle history of the synced value for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= q_o;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Per-domain reset generation gated by trigger, watchdog and instant-reset,
// with sticky fault handling and a delayed ramwriter release.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS       = 4,
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned WD_CNT_W          = 32,
  parameter int unsigned ALIVE_LOW_CYCLES  = 12500000,
  parameter int unsigned ALIVE_HIGH_CYCLES = 1250000
) (
  input  logic                   clk,
  input  logic                   peripheral_aresetn,
  input  logic [7:0]             reset_cfg,
  input  logic [WD_CNT_W-1:0]    wd_timeout,
  input  logic [15:0]            ramwriter_delay,
  input  logic [NUM_DOMAINS-1:0] domain_mask,
  input  logic                   trigger_in,
  input  logic                   watchdog_in,
  input  logic                   instant_reset_in,
  output logic                   write_to_ram_aresetn,
  output logic                   write_to_ramwriter_aresetn,
  output logic [NUM_DOMAINS-1:0] domain_aresetn,
  output logic                   xadc_aresetn,
  output logic                   reset_ack,
  output logic                   alive_signal,
  output logic                   master_trigger,
  output logic [31:0]            reset_sts
);

  localparam logic [31:0] ALIVE_LOW  = 32'(ALIVE_LOW_CYCLES);
  localparam logic [31:0] ALIVE_LAST = 32'(ALIVE_LOW_CYCLES + ALIVE_HIGH_CYCLES - 1);

  logic trg_s, trg_r, trg_f;
  logic wd_s, wd_r, wd_f;
  logic ins_s, ins_r, ins_f;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_trg (
    .clk_i(clk), .rst_ni(peripheral_aresetn), .d_i(trigger_in),
    .q_o(trg_s), .rise_o(trg_r), .fall_o(trg_f));
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_wd (
    .clk_i(clk), .rst_ni(peripheral_aresetn), .d_i(watchdog_in),
    .q_o(wd_s), .rise_o(wd_r), .fall_o(wd_f));
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ins (
    .clk_i(clk), .rst_ni(peripheral_aresetn), .d_i(instant_reset_in),
    .q_o(ins_s), .rise_o(ins_r), .fall_o(ins_f));

  logic unused_ok;
  assign unused_ok = ^{reset_cfg[7:6], trg_r, trg_f, ins_r, ins_f};

  gate_state_e            state_q, state_d;
  logic [WD_CNT_W-1:0]    wd_cnt_q, wd_cnt_d;
  logic [15:0]            rw_cnt_q, rw_cnt_d;
  logic [31:0]            alive_cnt_q, alive_cnt_d;
  logic                   clr_prev_q, trg_dly_q;
  logic                   ram_q, ram_d, rw_q, rw_d, xadc_q, xadc_d;
  logic                   ack_q, mtrig_q, alive_q, alive_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic [31:0]            sts_q, sts_d;
  logic                   wd_fault, cause, clr_rise, gate;

  assign wd_fault = reset_cfg[CFG_WD_EN] & (wd_timeout != '0) & (wd_cnt_q >= wd_timeout);
  assign cause    = wd_fault | (reset_cfg[CFG_INST_EN] & ins_s);
  assign clr_rise = reset_cfg[CFG_FAULT_CLR] & ~clr_prev_q;

  // Gate FSM next-state: fault has priority over trigger
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = reset_cfg[CFG_TRIG_MODE] ? ST_ARMED : ST_RUN;
      ST_ARMED: begin
        if (cause)                                   state_d = ST_FAULT;
        else if (!reset_cfg[CFG_TRIG_MODE] || trg_s) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cause)                                   state_d = ST_FAULT;
        else if (reset_cfg[CFG_TRIG_MODE] && !trg_s) state_d = ST_ARMED;
      end
      ST_FAULT: begin
        if (!cause && (!reset_cfg[CFG_STICKY] || clr_rise))
          state_d = reset_cfg[CFG_TRIG_MODE] ? ST_ARMED : ST_RUN;
      end
      default: state_d = ST_RESET;
    endcase
  end

  // Output, counter and status next values
  always_comb begin
    // An active cause closes the gate one cycle ahead of the FSM catching up,
    // so fault entry reaches the domain resets with a single cycle of latency.
    gate    = (state_q == ST_RUN) & ~cause;
    dom_d   = {NUM_DOMAINS{gate}} | ~domain_mask;
    ram_d   = (state_q != ST_RESET) & (~reset_cfg[CFG_TRIG_MODE] | trg_dly_q);
    xadc_d  = (state_q != ST_RESET);
    if (!ram_d) begin
      rw_d     = 1'b0;
      rw_cnt_d = '0;
    end else begin
      rw_d     = rw_q | (rw_cnt_q >= ramwriter_delay);
      rw_cnt_d = (rw_cnt_q == '1) ? rw_cnt_q : rw_cnt_q + 16'd1;
    end
    if (wd_r | wd_f)        wd_cnt_d = '0;
    else if (wd_cnt_q == '1) wd_cnt_d = wd_cnt_q;
    else                     wd_cnt_d = wd_cnt_q + 1'b1;
    alive_d     = (alive_cnt_q >= ALIVE_LOW);
    alive_cnt_d = (alive_cnt_q == ALIVE_LAST) ? '0 : alive_cnt_q + 32'd1;
    sts_d                          = '0;
    sts_d[STS_PERIPH]              = 1'b1;
    sts_d[STS_ANY_DOM]             = ~&dom_d;
    sts_d[STS_RAM]                 = ram_d;
    sts_d[STS_XADC]                = xadc_d;
    sts_d[STS_TRIG]                = trg_s;
    sts_d[STS_WD]                  = wd_s;
    sts_d[STS_INST]                = ins_s;
    sts_d[STS_MTRIG]               = reset_cfg[CFG_MASTER_TRIG];
    sts_d[STS_STATE +: 2]          = state_d;
    sts_d[STS_FAULT]               = (state_d == ST_FAULT);
    sts_d[STS_WD_FAULT]            = wd_fault;
    sts_d[STS_DOMAIN +: NUM_DOMAINS] = dom_d;
  end

  // State, counters and registered outputs; everything clears on reset
  always_ff @(posedge clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      state_q     <= ST_RESET;
      wd_cnt_q    <= '0;
      rw_cnt_q    <= '0;
      alive_cnt_q <= '0;
      clr_prev_q  <= 1'b0;
      trg_dly_q   <= 1'b0;
      ram_q       <= 1'b0;
      rw_q        <= 1'b0;
      dom_q       <= '0;
      xadc_q      <= 1'b0;
      ack_q       <= 1'b0;
      mtrig_q     <= 1'b0;
      alive_q     <= 1'b0;
      sts_q       <= '0;
    end else begin
      state_q     <= state_d;
      wd_cnt_q    <= wd_cnt_d;
      rw_cnt_q    <= rw_cnt_d;
      alive_cnt_q <= alive_cnt_d;
      clr_prev_q  <= reset_cfg[CFG_FAULT_CLR];
      trg_dly_q   <= trg_s;
      ram_q       <= ram_d;
      rw_q        <= rw_d;
      dom_q       <= dom_d;
      xadc_q      <= xadc_d;
      ack_q       <= wd_s;
      mtrig_q     <= reset_cfg[CFG_MASTER_TRIG];
      alive_q     <= alive_d;
      sts_q       <= sts_d;
    end
  end

  assign write_to_ram_aresetn       = ram_q;
  assign write_to_ramwriter_aresetn = rw_q;
  assign domain_aresetn             = dom_q;
  assign xadc_aresetn               = xadc_q;
  assign reset_ack                  = ack_q;
  assign alive_signal               = alive_q;
  assign master_trigger             = mtrig_q;
  assign reset_sts                  = sts_q;

endmodule
